// File: rtl/param_counter.sv
// Parameterised up/down counter with prescaler, wrap/saturate boundary policy,
// sticky overflow flag and a single-cycle wrap pulse.
module param_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = (2 ** WIDTH) - 1,
    parameter int unsigned SAT_MODE = 0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam int unsigned      PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
    localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;
    logic          step;
    logic          at_bound;

    // Step qualifier and boundary detect; tc is the boundary for the current direction.
    always_comb begin
        step     = en && (phase == PS_LAST);
        at_bound = up_dn ? (count == MAX_C) : (count == '0);
        tc       = at_bound;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            phase <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            phase <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= (load_val > MAX_C) ? MAX_C : load_val;
            phase <= '0;
            wrap  <= 1'b0;
        end else if (en) begin
            wrap <= 1'b0;
            if (!step) begin
                phase <= phase + PW'(1);
            end else begin
                phase <= '0;
                // Boundary step flags in both policies; only wrap mode moves the count.
                if (at_bound) begin
                    wrap <= 1'b1;
                    ovf  <= 1'b1;
                    if (SAT_MODE == 0) begin
                        count <= up_dn ? '0 : MAX_C;
                    end
                end else begin
                    count <= up_dn ? (count + WIDTH'(1)) : (count - WIDTH'(1));
                end
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: three parameterisations share one stimulus stream and
// are checked every cycle against an arithmetic model plus directed expectations.
module tb_param_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] c0, c1, c2;
    logic       t0, t1, t2, w0, w1, w2, o0, o1, o2;

    int n_checks = 0;
    int n_fail   = 0;

    // u0: defaults; u1: modulus 10 saturating; u2: prescale by 3 wrapping
    param_counter u0 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .count(c0), .tc(t0), .wrap(w0), .ovf(o0)
    );
    param_counter #(.WIDTH(4), .MAX_VAL(9), .SAT_MODE(1), .PRESCALE(1)) u1 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .count(c1), .tc(t1), .wrap(w1), .ovf(o1)
    );
    param_counter #(.WIDTH(4), .MAX_VAL(15), .SAT_MODE(0), .PRESCALE(3)) u2 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
        .load_val(load_val), .count(c2), .tc(t2), .wrap(w2), .ovf(o2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int cnt;
        int ph;
        bit wr;
        bit ov;
    } mst_t;

    mst_t m0 = '0;
    mst_t m1 = '0;
    mst_t m2 = '0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Next model state from the counter's rules, using modular arithmetic on integers
    function automatic mst_t mnext(input mst_t s, input int maxv, input bit sat, input int ps,
                                   input bit clr, input bit ld, input int lv,
                                   input bit e, input bit ud);
        mst_t n;
        bit   bnd;
        n    = s;
        n.wr = 1'b0;
        if (clr) begin
            n.cnt = 0;
            n.ph  = 0;
            n.ov  = 1'b0;
        end else if (ld) begin
            n.cnt = (lv < maxv) ? lv : maxv;
            n.ph  = 0;
        end else if (e) begin
            if (s.ph + 1 < ps) begin
                n.ph = s.ph + 1;
            end else begin
                n.ph = 0;
                bnd  = ud ? (s.cnt == maxv) : (s.cnt == 0);
                if (sat) n.cnt = ud ? ((s.cnt + 1 > maxv) ? maxv : s.cnt + 1)
                                    : ((s.cnt == 0) ? 0 : s.cnt - 1);
                else     n.cnt = ud ? (s.cnt + 1) % (maxv + 1)
                                    : (s.cnt + maxv) % (maxv + 1);
                if (bnd) begin
                    n.wr = 1'b1;
                    n.ov = 1'b1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m0 <= '0;
            m1 <= '0;
            m2 <= '0;
        end else begin
            m0 <= mnext(m0, 15, 1'b0, 1, clear, load, int'(load_val), en, up_dn);
            m1 <= mnext(m1, 9,  1'b1, 1, clear, load, int'(load_val), en, up_dn);
            m2 <= mnext(m2, 15, 1'b0, 3, clear, load, int'(load_val), en, up_dn);
        end
    end

    task automatic cmp(input string nm, input logic [3:0] c, input logic w, input logic o,
                       input logic t, input mst_t m, input int maxv);
        chk({nm, ".count"}, int'(c), m.cnt);
        chk({nm, ".wrap"}, int'(w), int'(m.wr));
        chk({nm, ".ovf"}, int'(o), int'(m.ov));
        chk({nm, ".tc"}, int'(t), int'((up_dn && m.cnt == maxv) || (!up_dn && m.cnt == 0)));
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        cmp("u0", c0, w0, o0, t0, m0, 15);
        cmp("u1", c1, w1, o1, t1, m1, 9);
        cmp("u2", c2, w2, o2, t2, m2, 15);
    end

    task automatic drive(input bit clr, input bit ld, input int lv, input bit e, input bit ud);
        clear    = clr;
        load     = ld;
        load_val = 4'(lv);
        en       = e;
        up_dn    = ud;
        @(posedge clk);
        #1;
    endtask

    int e34[17] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1};
    int e35[10] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 0};
    int s4_en[11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    int s4_ud[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    int s4_c[11]  = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 1};

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.count", int'(c0), 0);
        chk("rst.wrap", int'(w0), 0);
        chk("rst.ovf", int'(o0), 0);
        chk("rst.tc", int'(t0), 0);
        reset = 1'b0;

        // Free-running up count through the 15->0 wrap
        for (int k = 0; k < 17; k++) begin
            drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
            chk("s1.count", int'(c0), e34[k]);
            chk("s1.wrap", int'(w0), int'(k == 15));
            chk("s1.ovf", int'(o0), int'(k >= 15));
        end
        drive(1'b1, 1'b0, 0, 1'b0, 1'b1);
        chk("clr.count", int'(c0), 0);
        chk("clr.ovf", int'(o0), 0);

        // Saturating counter: clamped load then down past zero
        drive(1'b0, 1'b1, 12, 1'b0, 1'b0);
        chk("s2.load_clamp", int'(c1), 9);
        chk("s2.load_raw", int'(c0), 12);
        chk("s2.ovf_after_load", int'(o1), 0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
            chk("s2.count", int'(c1), e35[k]);
            chk("s2.wrap", int'(w1), int'(k == 9));
            chk("s2.ovf", int'(o1), int'(k == 9));
        end
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("s2.wrap_end", int'(w1), 0);
        chk("s2.ovf_sticky", int'(o1), 1);

        // Down from zero on the default counter
        drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
        chk("s3.tc_at_0", int'(t0), 1);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
        chk("s3.count", int'(c0), 15);
        chk("s3.wrap", int'(w0), 1);
        chk("s3.ovf", int'(o0), 1);
        drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
        chk("s3.wrap_end", int'(w0), 0);
        chk("s3.hold", int'(c0), 15);

        // Prescale by 3 with an enable gap and a mid-phase direction change
        drive(1'b1, 1'b0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 11; k++) begin
            drive(1'b0, 1'b0, 0, 1'(s4_en[k]), 1'(s4_ud[k]));
            chk("s4.count", int'(c2), s4_c[k]);
        end

        // Clear beats load and enable; load beats enable and resets the prescaler
        drive(1'b0, 1'b1, 15, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk("s5.ovf_set", int'(o0), 1);
        drive(1'b0, 1'b1, 5, 1'b0, 1'b1);
        chk("s5.load5", int'(c0), 5);
        chk("s5.ovf_kept", int'(o0), 1);
        drive(1'b1, 1'b1, 9, 1'b1, 1'b1);
        chk("s5.clr_count", int'(c0), 0);
        chk("s5.clr_ovf", int'(o0), 0);
        drive(1'b0, 1'b1, 7, 1'b1, 1'b1);
        chk("s5.load7_u0", int'(c0), 7);
        chk("s5.load7_u2", int'(c2), 7);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk("s5.step_u0", int'(c0), 8);
        chk("s5.nostep_u2", int'(c2), 7);

        // Asynchronous reset between edges at count 6 with ovf set
        drive(1'b0, 1'b1, 15, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 5, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk("s6.pre_count", int'(c0), 6);
        chk("s6.pre_ovf", int'(o0), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("s6.async_count", int'(c0), 0);
        chk("s6.async_ovf", int'(o0), 0);
        chk("s6.async_wrap", int'(w0), 0);
        drive(1'b0, 1'b1, 9, 1'b1, 1'b1);
        chk("s6.ignored", int'(c0), 0);
        reset = 1'b0;

        // First prescaled step lands on the third enabled cycle after reset
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk("s7.u2_c1", int'(c2), 0);
        chk("s7.u0_c1", int'(c0), 1);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk("s7.u2_c2", int'(c2), 0);
        drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
        chk("s7.u2_c3", int'(c2), 1);
        chk("s7.u0_c3", int'(c0), 3);

        drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
